// File: rtl/spi_slave_if.sv
// SPI slave front end for the command RAM: deserialises opcode+byte frames and serialises read bytes on MISO.
// Optional macro SPI_SLV_FRAME_ERR_EN adds a frame_err pulse for aborted frames and read-outs.
module spi_slave_if #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MOSI,
  input  logic              SS_n,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
`ifdef SPI_SLV_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);

  localparam int FRAME_W  = DATA_W + 2;
  localparam int CNT_W    = $clog2(FRAME_W + 1);
  localparam int TX_CNT_W = $clog2(DATA_W + 2);

  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0]    CNT_DONE = CNT_W'(FRAME_W);
  localparam logic [TX_CNT_W-1:0] TX_LAST  = TX_CNT_W'(DATA_W);
  localparam logic [TX_CNT_W-1:0] TX_DONE  = TX_CNT_W'(DATA_W + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CHK_CMD   = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] READ_ADD  = 3'd3;
  localparam logic [2:0] READ_DATA = 3'd4;

  logic [2:0]          state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [FRAME_W-2:0]  rx_sr;
  logic                rd_addr_seen;
  logic [DATA_W-1:0]   tx_sr;
  // tx_cnt: 0 waiting for tx_valid, 1..DATA_W bit on MISO, DATA_W+1 read-out finished
  logic [TX_CNT_W-1:0] tx_cnt;

  logic abort;
  assign abort = (state != IDLE) && SS_n;

  // NOTE: every register here is written with <= so all state updates use pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      rx_sr        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_seen <= 1'b0;
      tx_sr        <= '0;
      tx_cnt       <= '0;
      MISO         <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        bit_cnt <= '0;
        tx_cnt  <= '0;
        MISO    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            MISO    <= 1'b0;
            bit_cnt <= '0;
            tx_cnt  <= '0;
            if (!SS_n) state <= CHK_CMD;
          end
          CHK_CMD: begin
            rx_sr   <= {rx_sr[FRAME_W-3:0], MOSI};
            bit_cnt <= CNT_W'(1);
            if (!MOSI)             state <= WRITE;
            else if (rd_addr_seen) state <= READ_DATA;
            else                   state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (bit_cnt != CNT_DONE) begin
              rx_sr   <= {rx_sr[FRAME_W-3:0], MOSI};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_LAST) begin
                rx_data  <= {rx_sr, MOSI};
                rx_valid <= 1'b1;
                if (state == READ_ADD)  rd_addr_seen <= 1'b1;
                if (state == READ_DATA) rd_addr_seen <= 1'b0;
              end
            end else if (state == READ_DATA) begin
              if (tx_cnt == '0) begin
                if (tx_valid) begin
                  MISO   <= tx_data[DATA_W-1];
                  tx_sr  <= {tx_data[DATA_W-2:0], 1'b0};
                  tx_cnt <= TX_CNT_W'(1);
                end
              end else if (tx_cnt < TX_LAST) begin
                MISO   <= tx_sr[DATA_W-1];
                tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
                tx_cnt <= tx_cnt + 1'b1;
              end else begin
                MISO   <= 1'b0;
                tx_cnt <= TX_DONE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SPI_SLV_FRAME_ERR_EN
  logic frame_partial;
  logic readout_cut;
  assign frame_partial = (bit_cnt != '0) && (bit_cnt != CNT_DONE);
  assign readout_cut   = (state == READ_DATA) && (bit_cnt == CNT_DONE) && (tx_cnt < TX_LAST);

  always_ff @(posedge clk) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= abort && (frame_partial || readout_cut);
  end
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: directed frames from the test plan, then randomized frames/aborts
// checked against a transaction-level model (pending read-address flag, expected frame and MISO byte).
module tb_spi_slave_if;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              MOSI;
  logic              SS_n;
  logic              MISO;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
`ifdef SPI_SLV_FRAME_ERR_EN
  logic              frame_err;
`endif

  int checks = 0;
  int errors = 0;
  bit rd_seen = 1'b0;   // model: a READ_ADD frame is awaiting its READ_DATA frame

  spi_slave_if #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .MOSI     (MOSI),
    .SS_n     (SS_n),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
`ifdef SPI_SLV_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_err(input string tag, input logic exp);
`ifdef SPI_SLV_FRAME_ERR_EN
    check(tag, frame_err, exp);
`endif
  endtask

  // Runs one frame; n_bits < 10 aborts after that many bits. Returns whether the RAM should answer.
  task automatic do_frame(input logic [9:0] f, input int n_bits, output bit is_read_data);
    is_read_data = 1'b0;
    SS_n = 1'b0;
    tick();
    check("e0_no_valid", rx_valid, 1'b0);
    for (int i = 0; i < n_bits; i++) begin
      MOSI = f[9-i];
      tick();
      if (i < 9) check("early_valid", rx_valid, 1'b0);
    end
    if (n_bits == 10) begin
      check("rx_valid", rx_valid, 1'b1);
      check("rx_data", rx_data, f);
      if (f[9]) begin
        is_read_data = rd_seen;
        rd_seen      = !rd_seen;
      end
      for (int i = 0; i < 2; i++) begin
        MOSI = 1'($urandom);
        tick();
        check("single_valid", rx_valid, 1'b0);
        check("rx_data_hold", rx_data, f);
      end
    end else begin
      SS_n = 1'b1;
      tick();
      check("abort_no_valid", rx_valid, 1'b0);
      check("abort_miso", MISO, 1'b0);
      check_err("abort_err", 1'b1);
      tick();
      check_err("abort_err_drop", 1'b0);
    end
  endtask

  // After a complete frame: serve (or spuriously poke) tx_valid and watch MISO; optional reset mid read-out.
  task automatic service(input bit is_read, input logic [7:0] b, input int reset_at);
    if (is_read) begin
      tx_valid = 1'b0;
      for (int i = 0; i < $urandom_range(0, 3); i++) begin
        tick();
        check("wait_miso", MISO, 1'b0);
      end
      tx_data  = b;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
      for (int j = 0; j < 8; j++) begin
        check("miso_bit", MISO, b[7-j]);
        if (j + 1 == reset_at) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          rd_seen = 1'b0;
          check("rst_miso", MISO, 1'b0);
          check("rst_valid", rx_valid, 1'b0);
          check("rst_data", rx_data, 10'h000);
          break;
        end
        tick();
      end
      if (reset_at == 0) begin
        check("miso_after", MISO, 1'b0);
        tx_data  = 8'($urandom);
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("no_second_readout", MISO, 1'b0);
      end
    end else begin
      tx_data  = b;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
        check("spurious_tx", MISO, 1'b0);
        tick();
      end
    end
    SS_n = 1'b1;
    tick();
    check("end_miso", MISO, 1'b0);
    check_err("no_err_complete", 1'b0);
  endtask

  task automatic full(input logic [9:0] f, input logic [7:0] b, input int reset_at);
    bit rd;
    do_frame(f, 10, rd);
    service(rd, b, reset_at);
  endtask

  initial begin
    bit rd;
    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_data = '0; tx_valid = 1'b0;
    tick();
    tick();
    check("reset_miso", MISO, 1'b0);
    check("reset_valid", rx_valid, 1'b0);
    check("reset_data", rx_data, 10'h000);
    check_err("reset_err", 1'b0);
    rst = 1'b0;

    // Spurious tx_valid while idle
    tx_valid = 1'b1; tx_data = 8'hFF;
    tick();
    tx_valid = 1'b0;
    check("idle_tx_valid", MISO, 1'b0);

    full(10'h03A, 8'hA5, 0);   // write address
    full(10'h1C5, 8'h5A, 0);   // write data
    full(10'h23A, 8'h33, 0);   // read address
    full(10'h3E7, 8'hC5, 0);   // read data -> MISO 1,1,0,0,0,1,0,1

    // Abort after 5 bits, then a clean frame
    do_frame(10'h2F0, 5, rd);
    full(10'h0AB, 8'h11, 0);

    // Reset during the 4th read-out bit; next b9=1 frame must be a read address
    full(10'h211, 8'h00, 0);
    full(10'h399, 8'h96, 4);
    full(10'h244, 8'hFF, 0);
    full(10'h3C3, 8'h69, 0);

    // Randomized frames, opcodes and aborts
    for (int n = 0; n < 30; n++) begin
      logic [9:0] f;
      int nb;
      f  = 10'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 10;
      if (nb == 10) full(f, 8'($urandom), 0);
      else          do_frame(f, nb, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
